// File: rtl/controlador_de_status.sv
// rtl/controlador_de_status.sv - three-state preparation/attack status controller
//
// Purpose: sequences DESLIGADO -> PREPARACAO -> ATAQUE -> PREPARACAO ...
// with timed preparation and attack phases, a ready flag and an
// attack-completion pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   liga       in   system enable; low forces DESLIGADO on the next edge
//   disparo    in   attack request, honoured only once preparation is done
//   DESLIGADO  out  one-hot state indicator
//   PREPARACAO out  one-hot state indicator
//   ATAQUE     out  one-hot state indicator
//   status     out  encoded state: 00 DESLIGADO, 10 PREPARACAO, 11 ATAQUE
//   restante   out  cycles remaining in the current timed state
//   pronto     out  preparation complete (PREPARACAO with restante == 0)
//   concluido  out  one-cycle pulse on the first cycle after an attack ends

module controlador_de_status #(
    parameter int PREP_CYCLES = 4,
    parameter int ATK_CYCLES  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             liga,
    input  logic             disparo,
    output logic             DESLIGADO,
    output logic             PREPARACAO,
    output logic             ATAQUE,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] restante,
    output logic             pronto,
    output logic             concluido
);

    // The encoding equals the status code, so status is the state register.
    typedef enum logic [1:0] {
        ST_DESLIGADO  = 2'b00,
        ST_PREPARACAO = 2'b10,
        ST_ATAQUE     = 2'b11
    } estado_t;

    // Counters load N-1 so that a state lasts exactly N cycles (restante N-1..0).
    localparam logic [CNT_W-1:0] PREP_LOAD = CNT_W'(PREP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ATK_LOAD  = CNT_W'(ATK_CYCLES - 1);

    estado_t          state_q;
    logic [CNT_W-1:0] restante_q;
    logic             concluido_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_DESLIGADO;
            restante_q  <= '0;
            concluido_q <= 1'b0;
        end else begin
            concluido_q <= 1'b0;
            if (!liga) begin
                // Disable overrides everything, including a pending completion.
                state_q    <= ST_DESLIGADO;
                restante_q <= '0;
            end else begin
                case (state_q)
                    ST_DESLIGADO: begin
                        // disparo is deliberately not looked at here.
                        state_q    <= ST_PREPARACAO;
                        restante_q <= PREP_LOAD;
                    end
                    ST_PREPARACAO: begin
                        if (restante_q != '0) begin
                            restante_q <= restante_q - CNT_W'(1);
                        end else if (disparo) begin
                            state_q    <= ST_ATAQUE;
                            restante_q <= ATK_LOAD;
                        end
                    end
                    ST_ATAQUE: begin
                        if (restante_q != '0) begin
                            restante_q <= restante_q - CNT_W'(1);
                        end else begin
                            state_q     <= ST_PREPARACAO;
                            restante_q  <= PREP_LOAD;
                            concluido_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_DESLIGADO;
                        restante_q <= '0;
                    end
                endcase
            end
        end
    end

    assign DESLIGADO  = (state_q == ST_DESLIGADO);
    assign PREPARACAO = (state_q == ST_PREPARACAO);
    assign ATAQUE     = (state_q == ST_ATAQUE);
    assign status     = state_q;
    assign restante   = restante_q;
    assign pronto     = (state_q == ST_PREPARACAO) && (restante_q == '0);
    assign concluido  = concluido_q;

endmodule

// File: tb/tb_controlador_de_status.sv
// tb/tb_controlador_de_status.sv - self-checking bench for controlador_de_status

module tb_controlador_de_status;

    localparam int P = 4;
    localparam int A = 8;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset_n;
    logic       liga;
    logic       disparo;

    logic       desl, prep, atq, pronto, conc;
    logic [1:0] status;
    logic [7:0] restante;

    logic       desl1, prep1, atq1, pronto1, conc1;
    logic [1:0] status1;
    logic [7:0] restante1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    controlador_de_status #(.PREP_CYCLES(P), .ATK_CYCLES(A), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .liga(liga), .disparo(disparo),
        .DESLIGADO(desl), .PREPARACAO(prep), .ATAQUE(atq), .status(status),
        .restante(restante), .pronto(pronto), .concluido(conc)
    );

    controlador_de_status #(.PREP_CYCLES(1), .ATK_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .liga(liga), .disparo(disparo),
        .DESLIGADO(desl1), .PREPARACAO(prep1), .ATAQUE(atq1), .status(status1),
        .restante(restante1), .pronto(pronto1), .concluido(conc1)
    );

    initial forever #5 clk = clk_en ? ~clk : clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Model: state (0 off, 1 prep, 2 attack) plus cycles elapsed in that state;
    // restante and pronto are derived from elapsed time rather than a down-counter.
    int m_st = 0;
    int m_k = 0;
    bit m_conc = 1'b0;
    int m_ns;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st = 0; m_k = 0; m_conc = 1'b0;
        end else begin
            m_ns = m_st;
            if (!liga) m_ns = 0;
            else if (m_st == 0) m_ns = 1;
            else if (m_st == 1) begin
                if (m_k >= P - 1 && disparo) m_ns = 2;
            end else if (m_k == A - 1) m_ns = 1;
            m_conc = (m_st == 2 && m_ns == 1);
            m_k = (m_ns == m_st) ? m_k + 1 : 0;
            m_st = m_ns;
        end
    end

    function automatic int exp_rem();
        if (m_st == 1) return (P - 1 - m_k > 0) ? P - 1 - m_k : 0;
        if (m_st == 2) return A - 1 - m_k;
        return 0;
    endfunction

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("model_status", status, (m_st == 0) ? 0 : (m_st == 1) ? 2 : 3);
            chk("model_onehot", {desl, prep, atq}, (m_st == 0) ? 4 : (m_st == 1) ? 2 : 1);
            chk("model_restante", restante, exp_rem());
            chk("model_pronto", pronto, (m_st == 1 && m_k >= P - 1) ? 1 : 0);
            chk("model_concluido", conc, m_conc);
        end
    end

    task automatic edge_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_DESLIGADO"}, desl, 1);
        chk({tag, "_PREP"}, prep, 0);
        chk({tag, "_ATQ"}, atq, 0);
        chk({tag, "_status"}, status, 0);
        chk({tag, "_restante"}, restante, 0);
        chk({tag, "_pronto"}, pronto, 0);
        chk({tag, "_concluido"}, conc, 0);
        chk({tag, "_dut1_status"}, status1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    int rem_exp[19] = '{3, 2, 1, 0, 7, 6, 5, 4, 3, 2, 1, 0, 3, 2, 1, 0, 7, 6, 5};
    int st_exp[19]  = '{2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 2, 2, 2, 2, 3, 3, 3};

    initial begin
        reset_n = 1'b0;
        liga    = 1'b0;
        disparo = 1'b0;
        #3;
        chk_reset_vals("rst_clk_stopped");
        #10;
        reset_n = 1'b1;
        #2;
        chk_en = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        // Enable without attack request: count down then hold ready.
        liga = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge_wait();
            chk("prep_state", status, 2);
            chk("prep_restante", restante, (i < 4) ? 3 - i : 0);
            chk("prep_pronto", pronto, (i >= 3) ? 1 : 0);
        end
        @(negedge clk);
        liga = 1'b0;
        edge_wait();
        chk("off_status", status, 0);
        @(negedge clk);

        // Enable with disparo held: full prep/attack cycle, then abort at restante=5.
        liga = 1'b1;
        disparo = 1'b1;
        for (int c = 0; c < 19; c++) begin
            edge_wait();
            chk("cyc_status", status, st_exp[c]);
            chk("cyc_restante", restante, rem_exp[c]);
            chk("cyc_concluido", conc, (c == 12) ? 1 : 0);
            if (c == 0) chk("same_edge_no_attack", atq, 0);
            if (c < 6) begin
                chk("one_cyc_status", status1, (c % 2 == 0) ? 2 : 3);
                chk("one_cyc_restante", restante1, 0);
                chk("one_cyc_concluido", conc1, (c >= 2 && c % 2 == 0) ? 1 : 0);
            end
        end
        @(negedge clk);
        liga = 1'b0;
        edge_wait();
        chk("abort_status", status, 0);
        chk("abort_restante", restante, 0);
        chk("abort_concluido", conc, 0);
        @(negedge clk);

        // Asynchronous reset between edges during ATAQUE.
        liga = 1'b1;
        for (int c = 0; c < 6; c++) edge_wait();
        chk("pre_reset_attack", status, 3);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid_attack");
        #3;
        reset_n = 1'b1;
        edge_wait();
        chk("post_reset_status", status, 2);
        chk("post_reset_restante", restante, 3);
        chk("post_reset_concluido", conc, 0);
        @(negedge clk);

        // Free-running mix checked by the model only.
        for (int c = 0; c < 60; c++) begin
            disparo = 1'($urandom_range(0, 1));
            liga = ($urandom_range(0, 15) != 0);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
